issue_queue: RTL

- Parametrised in-order multi-issue instruction queue between decode/rename and the functional units.
- Accepts up to NR_IN decoded instructions per cycle and issues up to NR_ISSUE per cycle, strictly in program order.
- Blocks issue per FU class on that FU's ready signal.
- Allows at most one unresolved control-flow instruction in flight, and supports a single-cycle flush of all unissued entries.

---
 rtl/issue_queue.sv | 119 +++++++++++
 1 files changed

// File: rtl/issue_queue.sv
// In-order multi-issue instruction queue between rename and the functional units.
// Circular buffer with explicit count; issue gated per FU class and by a single outstanding branch.
module issue_queue #(
    parameter int DEPTH     = 8,
    parameter int NR_IN     = 2,
    parameter int NR_ISSUE  = 2,
    parameter int PAYLOAD_W = 64,
    parameter int NR_FU     = 4,
    localparam int FU_W     = (NR_FU > 1) ? $clog2(NR_FU) : 1,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic [NR_IN-1:0]              in_valid_i,
    input  logic [NR_IN*PAYLOAD_W-1:0]    in_payload_i,
    input  logic [NR_IN*FU_W-1:0]         in_fu_i,
    input  logic [NR_IN-1:0]              in_ctrl_flow_i,
    output logic [NR_IN-1:0]              in_ack_o,
    output logic [NR_ISSUE-1:0]           iss_valid_o,
    output logic [NR_ISSUE*PAYLOAD_W-1:0] iss_payload_o,
    output logic [NR_ISSUE*FU_W-1:0]      iss_fu_o,
    input  logic [NR_FU-1:0]              fu_ready_i,
    input  logic                          resolve_branch_i,
    output logic                          branch_pending_o,
    output logic [CNT_W-1:0]              count_o,
    output logic                          full_o,
    output logic                          empty_o
);

    logic [PAYLOAD_W-1:0] payload_q [DEPTH];
    logic [FU_W-1:0]      fu_q      [DEPTH];
    logic                 ctrl_q    [DEPTH];

    logic [PTR_W-1:0] head_q, tail_q;
    logic [PTR_W-1:0] iss_idx [NR_ISSUE];
    logic [CNT_W-1:0] free_slots, n_acc, n_iss;
    logic [NR_FU-1:0] fu_used;
    logic             prefix_ok, chain_ok, lane_ok, cf_used;

    assign free_slots = CNT_W'(DEPTH) - count_o;
    assign full_o     = (count_o == CNT_W'(DEPTH));
    assign empty_o    = (count_o == '0);

    // Free space comes from the registered count only, so same-cycle issues never feed enqueue.
    always_comb begin
        in_ack_o  = '0;
        n_acc     = '0;
        prefix_ok = 1'b1;
        for (int k = 0; k < NR_IN; k++) begin
            prefix_ok   = prefix_ok & in_valid_i[k];
            in_ack_o[k] = prefix_ok && (free_slots > CNT_W'(k)) && !flush_i;
            n_acc       = n_acc + CNT_W'(in_ack_o[k]);
        end
    end

    always_comb begin
        iss_valid_o   = '0;
        iss_payload_o = '0;
        iss_fu_o      = '0;
        n_iss         = '0;
        fu_used       = '0;
        cf_used       = 1'b0;
        chain_ok      = !flush_i;
        lane_ok       = 1'b0;
        for (int j = 0; j < NR_ISSUE; j++) begin
            iss_idx[j] = head_q + PTR_W'(j);
            iss_payload_o[j*PAYLOAD_W +: PAYLOAD_W] = payload_q[iss_idx[j]];
            iss_fu_o[j*FU_W +: FU_W]                = fu_q[iss_idx[j]];
            lane_ok = chain_ok
                   && (count_o > CNT_W'(j))
                   && fu_ready_i[fu_q[iss_idx[j]]]
                   && !fu_used[fu_q[iss_idx[j]]]
                   && (!ctrl_q[iss_idx[j]] || (!branch_pending_o && !cf_used));
            iss_valid_o[j] = lane_ok;
            chain_ok       = lane_ok;
            if (lane_ok) begin
                fu_used[fu_q[iss_idx[j]]] = 1'b1;
                cf_used = cf_used | ctrl_q[iss_idx[j]];
                n_iss   = n_iss + CNT_W'(1);
            end
        end
    end

    // Entry storage is never reset; validity is implied by head/count.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NR_IN; k++) begin
            if (in_ack_o[k]) begin
                payload_q[tail_q + PTR_W'(k)] <= in_payload_i[k*PAYLOAD_W +: PAYLOAD_W];
                fu_q[tail_q + PTR_W'(k)]      <= in_fu_i[k*FU_W +: FU_W];
                ctrl_q[tail_q + PTR_W'(k)]    <= in_ctrl_flow_i[k];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q           <= '0;
            tail_q           <= '0;
            count_o          <= '0;
            branch_pending_o <= 1'b0;
        end else if (flush_i) begin
            head_q           <= tail_q;
            count_o          <= '0;
            branch_pending_o <= 1'b0;
        end else begin
            tail_q  <= tail_q + n_acc[PTR_W-1:0];
            head_q  <= head_q + n_iss[PTR_W-1:0];
            count_o <= count_o + n_acc - n_iss;
            // A newly issued branch wins over a coincident resolve.
            if (cf_used)
                branch_pending_o <= 1'b1;
            else if (resolve_branch_i)
                branch_pending_o <= 1'b0;
        end
    end

endmodule
